cic_comp_fir: RTL

Decimate-by-2 compensation FIR stage that sits directly downstream of the CIC decimator. It consumes the CIC's signed `d_out` word, qualified by the rising edge of its `d_clk`, and applies a fixed 7-tap symmetric filter using one serial multiply-accumulate per clock. It emits every second filtered sample with a one-cycle valid strobe. All logic runs on the system `clk`; `d_clk` is treated as a synchronous level, not as a clock.

---
 rtl/cic_comp_fir.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: decimate-by-2, 7-tap symmetric compensation FIR behind a CIC.
// One serial MAC per clk; emits one rounded result per two accepted samples.
// Ports:
//   clk      system clock (same as the CIC)
//   rst      asynchronous active-high reset
//   d_in     signed sample from the CIC d_out
//   d_clk    CIC output strobe, sampled as a level; rising edge takes a sample
//   d_out    signed filtered, decimated sample, held between updates
//   d_valid  one-cycle pulse when d_out updates
//   overrun  sticky: a sample edge arrived while the MAC was busy
module cic_comp_fir #(
    parameter int unsigned IN_W  = 31,
    parameter int unsigned OUT_W = IN_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  d_in,
    input  logic                    d_clk,
    output logic signed [OUT_W-1:0] d_out,
    output logic                    d_valid,
    output logic                    overrun
);

    localparam int unsigned NTAP  = 7;
    localparam int unsigned ACC_W = IN_W + 9;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state, state_nxt;
    logic [2:0]              k, k_nxt;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic signed [IN_W-1:0]  x [NTAP];
    logic                    phase, phase_nxt;
    logic                    d_clk_q;
    logic                    overrun_nxt;
    logic signed [OUT_W-1:0] d_out_nxt;
    logic                    d_valid_nxt;

    logic                    rise_c;
    logic                    accept_c;
    logic signed [IN_W-1:0]  x_sel_c;
    logic signed [5:0]       coef_c;
    logic signed [ACC_W-1:0] prod_c;
    logic signed [ACC_W-1:0] rnd_c;

    // Tap select for the serial MAC; k never reaches 7
    always_comb begin
        x_sel_c = x[6];
        coef_c  = 6'sd0;
        case (k)
            3'd0: begin x_sel_c = x[0]; coef_c = -6'sd1;  end
            3'd1: begin x_sel_c = x[1]; coef_c =  6'sd0;  end
            3'd2: begin x_sel_c = x[2]; coef_c =  6'sd9;  end
            3'd3: begin x_sel_c = x[3]; coef_c =  6'sd16; end
            3'd4: begin x_sel_c = x[4]; coef_c =  6'sd9;  end
            3'd5: begin x_sel_c = x[5]; coef_c =  6'sd0;  end
            default: begin x_sel_c = x[6]; coef_c = -6'sd1; end
        endcase
    end

    // Next-state and output logic
    always_comb begin
        rise_c      = d_clk & ~d_clk_q;
        accept_c    = rise_c && (state == IDLE);
        prod_c      = ACC_W'(x_sel_c) * ACC_W'(coef_c);
        rnd_c       = acc + ACC_W'(16);

        state_nxt   = state;
        k_nxt       = k;
        acc_nxt     = acc;
        phase_nxt   = phase;
        d_out_nxt   = d_out;
        d_valid_nxt = 1'b0;
        // MAC and DONE both count as busy; an edge there is dropped
        overrun_nxt = overrun | (rise_c && (state != IDLE));

        case (state)
            IDLE: begin
                if (accept_c) begin
                    phase_nxt = ~phase;
                    if (phase) begin
                        state_nxt = MAC;
                        k_nxt     = 3'd0;
                        acc_nxt   = '0;
                    end
                end
            end
            MAC: begin
                acc_nxt = acc + prod_c;
                if (k == 3'd6) begin
                    state_nxt = DONE;
                end else begin
                    k_nxt = k + 3'd1;
                end
            end
            DONE: begin
                // Round half up, then drop the 2^5 coefficient scale
                d_out_nxt   = OUT_W'(rnd_c >>> 5);
                d_valid_nxt = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            k       <= 3'd0;
            acc     <= '0;
            phase   <= 1'b0;
            d_clk_q <= 1'b1;
            overrun <= 1'b0;
            d_out   <= '0;
            d_valid <= 1'b0;
            for (int i = 0; i < int'(NTAP); i++) begin
                x[i] <= '0;
            end
        end else begin
            state   <= state_nxt;
            k       <= k_nxt;
            acc     <= acc_nxt;
            phase   <= phase_nxt;
            d_clk_q <= d_clk;
            overrun <= overrun_nxt;
            d_out   <= d_out_nxt;
            d_valid <= d_valid_nxt;
            if (accept_c) begin
                x[0] <= d_in;
                for (int i = 1; i < int'(NTAP); i++) begin
                    x[i] <= x[i-1];
                end
            end
        end
    end

endmodule
